cla_multiword_sequencer: RTL and testbench
==========================================

Name: cla_multiword_sequencer

Overview:
Serial front-end for the existing carry_lookahead_adder: accepts wide operands as a stream of WIDTH-bit word pairs, least-significant word first. It feeds each pair to one carry_lookahead_adder instance and chains the carry across cycles through a carry register. It emits a registered stream of WIDTH-bit sum words plus a final carry-out. Sits directly upstream of, and wraps, the adder; its output stream is consumed by the result-collection logic.

Parameters:
WIDTH, 3, word width in bits; passed unchanged to carry_lookahead_adder.
MAX_WORDS, 4, maximum words per operand; the counter saturates and forces termination here.

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_rst  input  1  synchronous active-high reset
i_valid  input  1  input word pair valid
o_ready  output  1  block can accept a word pair this cycle
i_add1  input  WIDTH  operand A word
i_add2  input  WIDTH  operand B word
i_last  input  1  marks the most-significant word of the operand
o_valid  output  1  output word valid
i_ready  input  1  downstream accepts output word
o_sum  output  WIDTH  sum word
o_last  output  1  marks the final sum word of the operand
o_carry  output  1  final carry-out; meaningful only when o_last=1, else 0
o_len_err  output  1  operand was truncated at MAX_WORDS; meaningful with o_last=1, else 0

Behaviour:
- Reset, sampled on the i_clk edge while i_rst=1:
  - o_valid=0, o_sum=0, o_last=0, o_carry=0, o_len_err=0.
  - Internal carry register=0, word counter=0.
  - o_ready=0 while i_rst=1.
- Reset mid-operand discards the partial operand and any held output word. Nothing is emitted for it.
- Input handshake: a word is accepted when i_valid && o_ready.
  - o_ready = !i_rst && (!o_valid || i_ready): a single-entry output register with pass-through backpressure.
- Arithmetic per accepted word:
  - The adder computes r = i_add1 + i_add2 as WIDTH+1 bits.
  - t = r + carry_reg.
  - o_sum <= t[WIDTH-1:0].
  - word carry = t[WIDTH]. Sum of two WIDTH-bit words plus 1 never exceeds WIDTH+1 bits.
- Latency: exactly 1 cycle from acceptance to o_valid=1 with the corresponding sum.
- Output hold: o_valid, o_sum, o_last, o_carry and o_len_err stay stable while o_valid && !i_ready.
- Accept with i_ready=1 in the same cycle: the output register is replaced with no bubble, giving full throughput of 1 word/cycle.
- Termination: a word is final if i_last=1 or word counter == MAX_WORDS-1.
- On a final word:
  - o_last <= 1, o_carry <= word carry.
  - o_len_err <= (counter == MAX_WORDS-1 && !i_last).
  - carry_reg <= 0, counter <= 0.
  - The next accepted word starts a new operand.
- On a non-final word:
  - o_last <= 0, o_carry <= 0, o_len_err <= 0.
  - carry_reg <= word carry, counter <= counter+1.
- When no word is accepted: carry_reg and counter hold.
- When the output register is consumed with no new accept, o_valid <= 0. Data fields may hold stale values.
- Single-word operand (i_last on the first word): behaves as a single registered add, carry_in=0.
- Stall boundary: i_valid low mid-operand preserves carry_reg and counter indefinitely.

Test Plan:
- Reset, then a single word with i_last=1, a=5, b=6, i_ready=1 -> next cycle o_valid=1, o_sum=3, o_carry=1, o_last=1, o_len_err=0.
- Two-word operand, A=7,7 and B=1,0 (LSW first), back-to-back, i_ready=1 -> sums 0 then 0; second word o_last=1, o_carry=1. 2-cycle throughput, no bubble.
- Backpressure: hold i_ready=0 for 3 cycles with the first output valid -> o_ready=0, outputs stable; release -> next word accepted the same cycle and carry chaining correct (A=3,2 B=5,1 -> 0,4, o_carry=0).
- Truncation: 4 words of 7+7 with i_last never asserted -> sums 6,7,7,7; 4th word o_last=1, o_len_err=1, o_carry=1; a following word restarts with carry_in=0.
- Reset mid-operand: accept 2 non-last words 7+1, assert i_rst one cycle -> all outputs 0. Then a=1,b=1,i_last=1 -> o_sum=2, o_carry=0, showing no stale carry.
- Exhaustive single-word sweep, a,b in 0..7 with i_last=1 -> {o_carry,o_sum} == a+b for all 64 pairs, zero errors.

Source files
------------

// File: rtl/cla_multiword_sequencer.sv
// Multi-word serial adder front-end: streams WIDTH-bit word pairs (LSW first)
// through one carry_lookahead_adder, chaining the carry across cycles.

module carry_lookahead_adder #(
   parameter int WIDTH = 3
) (
   input  logic [WIDTH-1:0] i_add1,
   input  logic [WIDTH-1:0] i_add2,
   output logic [WIDTH:0]   o_result
);

   logic [WIDTH-1:0] gen;
   logic [WIDTH-1:0] prop;
   logic [WIDTH:0]   carry;

   // Each carry is the flattened OR of generate terms gated by later propagates,
   // so no carry depends on the one below it.
   function automatic logic [WIDTH:0] lookahead(input logic [WIDTH-1:0] g,
                                                input logic [WIDTH-1:0] p);
      logic [WIDTH:0] c;
      logic           acc;
      logic           prod;
      c = '0;
      for (int i = 0; i < WIDTH; i++) begin
         acc = 1'b0;
         for (int j = 0; j <= i; j++) begin
            prod = g[j];
            for (int k = j + 1; k <= i; k++) prod = prod & p[k];
            acc = acc | prod;
         end
         c[i+1] = acc;
      end
      return c;
   endfunction

   assign gen      = i_add1 & i_add2;
   assign prop     = i_add1 ^ i_add2;
   assign carry    = lookahead(gen, prop);
   assign o_result = {carry[WIDTH], prop ^ carry[WIDTH-1:0]};

endmodule

module cla_multiword_sequencer #(
   parameter int WIDTH     = 3,
   parameter int MAX_WORDS = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_add1,
   input  logic [WIDTH-1:0] i_add2,
   input  logic             i_last,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_last,
   output logic             o_carry,
   output logic             o_len_err
);

   localparam int CW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(MAX_WORDS - 1);

   logic [WIDTH:0]  add_r;
   logic [WIDTH:0]  add_t;
   logic            carry_reg;
   logic [CW-1:0]   count;
   logic            accept;
   logic            at_limit;
   logic            is_final;

   carry_lookahead_adder #(.WIDTH(WIDTH)) u_adder (
      .i_add1   (i_add1),
      .i_add2   (i_add2),
      .o_result (add_r)
   );

   // a+b+1 always fits in WIDTH+1 bits, so the chained carry cannot overflow.
   assign add_t    = add_r + {{WIDTH{1'b0}}, carry_reg};
   assign o_ready  = !i_rst && (!o_valid || i_ready);
   assign accept   = i_valid && o_ready;
   assign at_limit = (count == LAST_IDX);
   assign is_final = i_last || at_limit;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_valid   <= 1'b0;
         o_sum     <= '0;
         o_last    <= 1'b0;
         o_carry   <= 1'b0;
         o_len_err <= 1'b0;
         carry_reg <= 1'b0;
         count     <= '0;
      end else if (accept) begin
         o_valid   <= 1'b1;
         o_sum     <= add_t[WIDTH-1:0];
         o_last    <= is_final;
         o_carry   <= is_final && add_t[WIDTH];
         o_len_err <= is_final && at_limit && !i_last;
         if (is_final) begin
            carry_reg <= 1'b0;
            count     <= '0;
         end else begin
            carry_reg <= add_t[WIDTH];
            count     <= count + 1'b1;
         end
      end else if (i_ready) begin
         o_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cla_multiword_sequencer.sv
// Directed bench for cla_multiword_sequencer; output bundle compared as
// {o_valid, o_sum, o_last, o_carry, o_len_err}.

module tb_cla_multiword_sequencer;

   localparam int WIDTH = 3;

   logic             i_clk = 1'b0;
   logic             i_rst;
   logic             i_valid;
   logic             o_ready;
   logic [WIDTH-1:0] i_add1;
   logic [WIDTH-1:0] i_add2;
   logic             i_last;
   logic             o_valid;
   logic             i_ready;
   logic [WIDTH-1:0] o_sum;
   logic             o_last;
   logic             o_carry;
   logic             o_len_err;

   logic [6:0] obs;
   int passed = 0;
   int total  = 0;

   assign obs = {o_valid, o_sum, o_last, o_carry, o_len_err};

   cla_multiword_sequencer #(.WIDTH(WIDTH), .MAX_WORDS(4)) dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_valid   (i_valid),
      .o_ready   (o_ready),
      .i_add1    (i_add1),
      .i_add2    (i_add2),
      .i_last    (i_last),
      .o_valid   (o_valid),
      .i_ready   (i_ready),
      .o_sum     (o_sum),
      .o_last    (o_last),
      .o_carry   (o_carry),
      .o_len_err (o_len_err)
   );

   always #5 i_clk = ~i_clk;

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] a, input logic [2:0] b,
                        input logic l);
      i_valid = v;
      i_add1  = a;
      i_add2  = b;
      i_last  = l;
   endtask

   task automatic test_reset();
      i_rst = 1'b1; i_ready = 1'b1;
      drive(1'b0, 3'd0, 3'd0, 1'b0);
      step(); step();
      if (obs !== 7'b0) $display("FAIL reset_out: got %b want %b", obs, 7'b0);
      else passed++;
      total++;
      if (o_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", o_ready);
      else passed++;
      total++;
      i_rst = 1'b0;
      #1;
      if (o_ready !== 1'b1) $display("FAIL ready_after_reset: got %b want 1", o_ready);
      else passed++;
      total++;
   endtask

   task automatic test_single();
      drive(1'b1, 3'd5, 3'd6, 1'b1);
      step();
      drive(1'b0, 3'd0, 3'd0, 1'b0);
      if (obs !== {1'b1, 3'd3, 1'b1, 1'b1, 1'b0})
         $display("FAIL single_5p6: got %b want %b", obs, {1'b1, 3'd3, 3'b110});
      else passed++;
      total++;
      step();
      if (o_valid !== 1'b0) $display("FAIL single_drain: o_valid got %b want 0", o_valid);
      else passed++;
      total++;
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 3'd7, 3'd1, 1'b0);
      step();
      if (obs !== {1'b1, 3'd0, 3'b000})
         $display("FAIL b2b_w0: got %b want %b", obs, {1'b1, 3'd0, 3'b000});
      else passed++;
      total++;
      drive(1'b1, 3'd7, 3'd0, 1'b1);
      if (o_ready !== 1'b1) $display("FAIL b2b_ready: got %b want 1", o_ready);
      else passed++;
      total++;
      step();
      drive(1'b0, 3'd0, 3'd0, 1'b0);
      if (obs !== {1'b1, 3'd0, 3'b110})
         $display("FAIL b2b_w1: got %b want %b", obs, {1'b1, 3'd0, 3'b110});
      else passed++;
      total++;
      step();
   endtask

   task automatic test_backpressure();
      i_ready = 1'b0;
      drive(1'b1, 3'd3, 3'd5, 1'b0);
      step();
      drive(1'b1, 3'd2, 3'd1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         if (o_ready !== 1'b0 || obs !== {1'b1, 3'd0, 3'b000})
            $display("FAIL bp_hold%0d: ready=%b out=%b want ready=0 out=%b",
                     i, o_ready, obs, {1'b1, 3'd0, 3'b000});
         else passed++;
         total++;
         step();
      end
      i_ready = 1'b1;
      #1;
      if (o_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", o_ready);
      else passed++;
      total++;
      step();
      drive(1'b0, 3'd0, 3'd0, 1'b0);
      if (obs !== {1'b1, 3'd4, 3'b100})
         $display("FAIL bp_w1: got %b want %b", obs, {1'b1, 3'd4, 3'b100});
      else passed++;
      total++;
      step();
   endtask

   task automatic test_truncation();
      logic [2:0] exp_sum [4] = '{3'd6, 3'd7, 3'd7, 3'd7};
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 3'd7, 3'd7, 1'b0);
         step();
         if (obs !== {1'b1, exp_sum[i], (i == 3) ? 3'b111 : 3'b000})
            $display("FAIL trunc_w%0d: got %b want %b", i, obs,
                     {1'b1, exp_sum[i], (i == 3) ? 3'b111 : 3'b000});
         else passed++;
         total++;
      end
      drive(1'b1, 3'd1, 3'd1, 1'b1);
      step();
      drive(1'b0, 3'd0, 3'd0, 1'b0);
      if (obs !== {1'b1, 3'd2, 3'b100})
         $display("FAIL trunc_restart: got %b want %b", obs, {1'b1, 3'd2, 3'b100});
      else passed++;
      total++;
      step();
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 3'd7, 3'd1, 1'b0);
      step(); step();
      drive(1'b0, 3'd0, 3'd0, 1'b0);
      i_rst = 1'b1;
      step();
      if (obs !== 7'b0 || o_ready !== 1'b0)
         $display("FAIL midrst_out: got out=%b ready=%b want out=%b ready=0",
                  obs, o_ready, 7'b0);
      else passed++;
      total++;
      i_rst = 1'b0;
      drive(1'b1, 3'd1, 3'd1, 1'b1);
      step();
      drive(1'b0, 3'd0, 3'd0, 1'b0);
      if (obs !== {1'b1, 3'd2, 3'b100})
         $display("FAIL midrst_fresh: got %b want %b", obs, {1'b1, 3'd2, 3'b100});
      else passed++;
      total++;
      step();
   endtask

   task automatic test_sweep();
      logic [3:0] expv;
      for (int a = 0; a < 8; a++) begin
         for (int b = 0; b < 8; b++) begin
            drive(1'b1, 3'(a), 3'(b), 1'b1);
            step();
            expv = 4'(a + b);
            if ({o_valid, o_last, o_carry, o_sum} !== {2'b11, expv})
               $display("FAIL sweep_%0d_%0d: got v=%b l=%b sum=%0d want sum=%0d",
                        a, b, o_valid, o_last, {o_carry, o_sum}, expv);
            else passed++;
            total++;
         end
      end
      drive(1'b0, 3'd0, 3'd0, 1'b0);
      step();
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_truncation();
      test_reset_mid();
      test_sweep();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
